// File: rtl/rt_pixel_packer.sv
// -----------------------------------------------------------------------------
// rt_pixel_packer
//
// Packs a stream of 24-bit RGB pixels (one per in_valid/in_ready handshake)
// into a 32-bit AXI4-Stream video bus. Default mode is 24 bpp packed: the
// byte stream R0 G0 B0 R1 G1 B1 ... fills word lanes from lane 0 upward, so
// four pixels make three words. A line that ends mid-word is flushed with
// PAD_BYTE in the unused lanes.
//
// Optional feature: define RT_PACKER_RGBX_EN to emit one word per pixel,
// {PAD_BYTE, B, G, R}, with in_sof/in_last_x mapped straight to tuser/tlast.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid & ready are both 1. valid, once raised, is held with stable
// payload until the transfer. in_ready is a combinational function of the
// FSM state, out_tvalid and out_tready only (never of in_valid).
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   in_valid/in_ready    pixel handshake
//   in_r, in_g, in_b     pixel colour
//   in_sof               first pixel of a frame
//   in_last_x            last pixel of a line
//   out_tdata[31:0]      stream word, lane 0 = [7:0]
//   out_tvalid/tready    stream handshake
//   out_tlast            last word of a line
//   out_tuser            first word of a frame
//   misalign_err         sticky: in_sof arrived with bytes still held
//   dbg_state            FSM state (0 = PACK, 1 = FLUSH)
//   dbg_ph[1:0]          packing phase
// -----------------------------------------------------------------------------
module rt_pixel_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_sof,
    input  logic        in_last_x,
    output logic        in_ready,
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic        out_tuser,
    output logic        misalign_err,
    output logic        dbg_state,
    output logic [1:0]  dbg_ph
);

    typedef enum logic {
        ST_PACK  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ph;
    logic [7:0]  r_h0;
    logic [7:0]  r_h1;
    logic [7:0]  r_h2;
    logic [31:0] r_flush_word;
    logic        r_pend_user;
    logic        r_err;
    logic [31:0] r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_tuser;

    logic        w_out_free;
    logic        w_in_ready;
    logic        w_acc;

    state_t      w_nxt_state;
    logic [1:0]  w_nxt_ph;
    logic [1:0]  w_ph_eff;
    logic [7:0]  w_nxt_h0;
    logic [7:0]  w_nxt_h1;
    logic [7:0]  w_nxt_h2;
    logic [31:0] w_nxt_flush;
    logic        w_nxt_pend;
    logic        w_nxt_err;
    logic        w_user_now;
    logic        w_load;
    logic [31:0] w_word;
    logic        w_wlast;
    logic        w_wuser;

    // The output register can take a new word when empty or being drained.
    assign w_out_free = !r_tvalid || out_tready;
    assign w_in_ready = (r_state == ST_PACK) && w_out_free;
    assign w_acc      = in_valid && w_in_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ph    = r_ph;
        w_ph_eff    = r_ph;
        w_nxt_h0    = r_h0;
        w_nxt_h1    = r_h1;
        w_nxt_h2    = r_h2;
        w_nxt_flush = r_flush_word;
        w_nxt_pend  = r_pend_user;
        w_nxt_err   = r_err;
        w_user_now  = 1'b0;
        w_load      = 1'b0;
        w_word      = r_tdata;
        w_wlast     = 1'b0;
        w_wuser     = 1'b0;

`ifdef RT_PACKER_RGBX_EN
        // One word per pixel; phase, hold bytes and FLUSH stay idle.
        if (w_acc) begin
            w_load  = 1'b1;
            w_word  = {PAD_BYTE, in_b, in_g, in_r};
            w_wlast = in_last_x;
            w_wuser = in_sof;
        end
`else
        case (r_state)
            ST_PACK: begin
                if (w_acc) begin
                    // A frame start always restarts packing at phase 0;
                    // any bytes still held from the old line are dropped.
                    w_ph_eff = in_sof ? 2'd0 : r_ph;
                    if (in_sof && (r_ph != 2'd0)) begin
                        w_nxt_err = 1'b1;
                    end
                    w_user_now = r_pend_user || in_sof;

                    case (w_ph_eff)
                        2'd0: begin
                            if (in_last_x) begin
                                w_load  = 1'b1;
                                w_word  = {PAD_BYTE, in_b, in_g, in_r};
                                w_wlast = 1'b1;
                            end else begin
                                w_nxt_h0 = in_r;
                                w_nxt_h1 = in_g;
                                w_nxt_h2 = in_b;
                            end
                        end
                        2'd1: begin
                            // h0..h2 = R0 G0 B0
                            w_load   = 1'b1;
                            w_word   = {in_r, r_h2, r_h1, r_h0};
                            w_nxt_h0 = in_g;
                            w_nxt_h1 = in_b;
                            if (in_last_x) begin
                                w_nxt_flush = {PAD_BYTE, PAD_BYTE, in_b, in_g};
                                w_nxt_state = ST_FLUSH;
                            end
                        end
                        2'd2: begin
                            // h0,h1 = G1 B1
                            w_load   = 1'b1;
                            w_word   = {in_g, in_r, r_h1, r_h0};
                            w_nxt_h0 = in_b;
                            if (in_last_x) begin
                                w_nxt_flush = {PAD_BYTE, PAD_BYTE, PAD_BYTE, in_b};
                                w_nxt_state = ST_FLUSH;
                            end
                        end
                        default: begin
                            // h0 = B2
                            w_load  = 1'b1;
                            w_word  = {in_b, in_g, in_r, r_h0};
                            w_wlast = in_last_x;
                        end
                    endcase

                    w_wuser    = w_user_now;
                    // The user flag rides on the first word that actually goes out.
                    w_nxt_pend = w_load ? 1'b0 : w_user_now;
                    w_nxt_ph   = in_last_x ? 2'd0 : (w_ph_eff + 2'd1);
                end
            end
            ST_FLUSH: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_word      = r_flush_word;
                    w_wlast     = 1'b1;
                    w_wuser     = r_pend_user;
                    w_nxt_pend  = 1'b0;
                    w_nxt_state = ST_PACK;
                end
            end
            default: begin
                w_nxt_state = ST_PACK;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_PACK;
            r_ph         <= 2'd0;
            r_h0         <= 8'h00;
            r_h1         <= 8'h00;
            r_h2         <= 8'h00;
            r_flush_word <= 32'h0;
            r_pend_user  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_ph         <= w_nxt_ph;
            r_h0         <= w_nxt_h0;
            r_h1         <= w_nxt_h1;
            r_h2         <= w_nxt_h2;
            r_flush_word <= w_nxt_flush;
            r_pend_user  <= w_nxt_pend;
            r_err        <= w_nxt_err;
        end
    end

    // Output register: payload only changes when a new word is loaded, so it
    // stays stable through a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tdata  <= 32'h0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else if (w_out_free) begin
            r_tvalid <= w_load;
            if (w_load) begin
                r_tdata <= w_word;
                r_tlast <= w_wlast;
                r_tuser <= w_wuser;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_tdata    = r_tdata;
    assign out_tvalid   = r_tvalid;
    assign out_tlast    = r_tlast;
    assign out_tuser    = r_tuser;
    assign misalign_err = r_err;
    assign dbg_state    = r_state;
    assign dbg_ph       = r_ph;

endmodule

// File: tb/tb_rt_pixel_packer.sv
module tb_rt_pixel_packer;

  localparam logic [7:0] PAD = 8'h00;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        in_sof;
  logic        in_last_x;
  logic        in_ready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic        out_tuser;
  logic        misalign_err;
  logic        dbg_state;
  logic [1:0]  dbg_ph;

  rt_pixel_packer #(.PAD_BYTE(PAD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .in_sof      (in_sof),
    .in_last_x   (in_last_x),
    .in_ready    (in_ready),
    .out_tdata   (out_tdata),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tlast   (out_tlast),
    .out_tuser   (out_tuser),
    .misalign_err(misalign_err),
    .dbg_state   (dbg_state),
    .dbg_ph      (dbg_ph)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // entry = {tuser, tlast, tdata}
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  logic [7:0]  byte_q[$];
  int          rd_idx;
  logic        m_pend;
  logic        m_err;
  int          errors;
  int          checks;
  int          stab_viol;
  logic        rnd_rdy;

  // ---------------- monitor ----------------
  logic        p_stall;
  logic [33:0] p_word;

  initial begin
    stab_viol = 0;
    p_stall   = 1'b0;
    p_word    = '0;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (p_stall && (!out_tvalid || ({out_tuser, out_tlast, out_tdata} !== p_word)))
        stab_viol <= stab_viol + 1;
      if (out_tvalid && out_tready)
        obs_q.push_back({out_tuser, out_tlast, out_tdata});
      p_stall <= out_tvalid && !out_tready;
      p_word  <= {out_tuser, out_tlast, out_tdata};
    end else begin
      p_stall <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Byte-stream view: every pixel appends R,G,B to the line's pending bytes;
  // any four pending bytes form a word; a line end pads what is left.
  task automatic model_pixel(input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic sof, input logic last);
    logic [31:0] w;
`ifdef RT_PACKER_RGBX_EN
    exp_q.push_back({sof, last, PAD, b, g, r});
`else
    if (sof) begin
      if (byte_q.size() != 0) m_err = 1'b1;
      byte_q.delete();
      m_pend = 1'b1;
    end
    byte_q.push_back(r);
    byte_q.push_back(g);
    byte_q.push_back(b);
    while (byte_q.size() >= 4) begin
      w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
      for (int k = 0; k < 4; k++) void'(byte_q.pop_front());
      exp_q.push_back({m_pend, (last && byte_q.size() == 0), w});
      m_pend = 1'b0;
    end
    if (last && byte_q.size() != 0) begin
      while (byte_q.size() < 4) byte_q.push_back(PAD);
      w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
      byte_q.delete();
      exp_q.push_back({m_pend, 1'b1, w});
      m_pend = 1'b0;
    end
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic sof, input logic last);
    bit done;
    done      = 1'b0;
    in_r      = r;
    in_g      = g;
    in_b      = b;
    in_sof    = sof;
    in_last_x = last;
    in_valid  = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (rnd_rdy) out_tready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    if (done) begin
      model_pixel(r, g, b, sof, last);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    bit idle;
    idle       = 1'b0;
    rnd_rdy    = 1'b0;
    out_tready = 1'b1;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(negedge clk);
      idle = (obs_q.size() >= exp_q.size()) && !out_tvalid && (dbg_state == 1'b0);
      @(posedge clk);
      #1;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: obs=%0d words, required %0d", obs_q.size(), exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_r       = 8'h00;
    in_g       = 8'h00;
    in_b       = 8'h00;
    in_sof     = 1'b0;
    in_last_x  = 1'b0;
    out_tready = 1'b1;
    rnd_rdy    = 1'b0;
    m_pend     = 1'b0;
    m_err      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", out_tvalid); end
    checks++; if (out_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 00000000", out_tdata); end
    checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", out_tlast); end
    checks++; if (out_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b want 0", out_tuser); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", misalign_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int base;
    base = exp_q.size();
    send_pixel(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
    send_pixel(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    send_pixel(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
    send_pixel(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
    drain();
`ifndef RT_PACKER_RGBX_EN
    checks++;
    if (obs_q.size() < base + 3) begin
      errors++; $display("FAIL basic_count: got %0d words want %0d", obs_q.size() - base, 3);
    end else begin
      checks++; if (obs_q[base] !== {1'b1, 1'b0, 32'h04030201}) begin errors++; $display("FAIL basic_w0: got %h want 204030201", obs_q[base]); end
      checks++; if (obs_q[base+1] !== {1'b0, 1'b0, 32'h08070605}) begin errors++; $display("FAIL basic_w1: got %h want 008070605", obs_q[base+1]); end
      checks++; if (obs_q[base+2] !== {1'b0, 1'b1, 32'h0C0B0A09}) begin errors++; $display("FAIL basic_w2: got %h want 10C0B0A09", obs_q[base+2]); end
    end
`endif
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL basic_missing: word %0d absent, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++; $display("FAIL basic_word: idx %0d got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
  endtask

  task automatic test_flush();
    int lows;
    int want_lows;
    lows = 0;
`ifdef RT_PACKER_RGBX_EN
    want_lows = 0;
`else
    want_lows = 1;
`endif
    send_pixel(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    send_pixel(8'h44, 8'h55, 8'h66, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (!in_ready) lows++;
    end
    @(posedge clk);
    #1;
    checks++; if (lows !== want_lows) begin errors++; $display("FAIL flush_ready_low: got %0d cycles want %0d", lows, want_lows); end
    drain();
`ifndef RT_PACKER_RGBX_EN
    checks++;
    if (obs_q.size() < rd_idx + 2) begin
      errors++; $display("FAIL flush_count: got %0d words want 2", obs_q.size() - rd_idx);
    end else begin
      checks++; if (obs_q[rd_idx] !== {1'b0, 1'b0, 32'h44332211}) begin errors++; $display("FAIL flush_w0: got %h want 044332211", obs_q[rd_idx]); end
      checks++; if (obs_q[rd_idx+1] !== {1'b0, 1'b1, 32'h00006655}) begin errors++; $display("FAIL flush_w1: got %h want 100006655", obs_q[rd_idx+1]); end
    end
`endif
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL flush_missing: word %0d absent, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++; $display("FAIL flush_word: idx %0d got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
  endtask

  task automatic test_stall();
    int v0;
    out_tready = 1'b0;
    v0 = stab_viol;
    send_pixel(8'hA1, 8'hA2, 8'hA3, 1'b0, 1'b0);
    send_pixel(8'hA4, 8'hA5, 8'hA6, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", n, in_ready); end
      checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid: cycle %0d got %b want 1", n, out_tvalid); end
      @(posedge clk);
      #1;
    end
    out_tready = 1'b1;
    send_pixel(8'hA7, 8'hA8, 8'hA9, 1'b0, 1'b0);
    send_pixel(8'hAA, 8'hAB, 8'hAC, 1'b0, 1'b1);
    drain();
    checks++; if (stab_viol !== v0) begin errors++; $display("FAIL stall_stable: got %0d payload changes want 0", stab_viol - v0); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL stall_missing: word %0d absent, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++; $display("FAIL stall_word: idx %0d got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
  endtask

  task automatic test_sof_misalign();
    send_pixel(8'hB1, 8'hB2, 8'hB3, 1'b1, 1'b0);
    send_pixel(8'hB4, 8'hB5, 8'hB6, 1'b0, 1'b0);
    send_pixel(8'hC1, 8'hC2, 8'hC3, 1'b1, 1'b0);
    send_pixel(8'hC4, 8'hC5, 8'hC6, 1'b0, 1'b0);
    send_pixel(8'hC7, 8'hC8, 8'hC9, 1'b0, 1'b1);
    drain();
    checks++; if (misalign_err !== m_err) begin errors++; $display("FAIL sof_err: got %b want %b", misalign_err, m_err); end
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL sof_missing: word %0d absent, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++; $display("FAIL sof_word: idx %0d got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
  endtask

  // Single-pixel line with sof+last: one word, one cycle after acceptance.
  task automatic test_single_pixel();
    send_pixel(8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1);
    checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid: got %b want 1", out_tvalid); end
    checks++; if (out_tdata !== 32'h00CCBBAA) begin errors++; $display("FAIL single_tdata: got %h want 00CCBBAA", out_tdata); end
    checks++; if (out_tlast !== 1'b1) begin errors++; $display("FAIL single_tlast: got %b want 1", out_tlast); end
    checks++; if (out_tuser !== 1'b1) begin errors++; $display("FAIL single_tuser: got %b want 1", out_tuser); end
    drain();
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL single_missing: word %0d absent, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++; $display("FAIL single_word: idx %0d got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
  endtask

  task automatic test_random();
    logic sof;
    logic last;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sof  = ($urandom_range(0, 19) == 0);
      last = ($urandom_range(0, 6) == 0);
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), sof, last);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    send_pixel(8'h5A, 8'h6B, 8'h7C, 1'b0, 1'b1);
    drain();
    checks++; if (misalign_err !== m_err) begin errors++; $display("FAIL random_err: got %b want %b", misalign_err, m_err); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL random_missing: word %0d absent, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++; $display("FAIL random_word: idx %0d got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rd_idx = 0;
    test_reset();
    test_basic();
    test_flush();
    test_stall();
    test_sof_misalign();
    test_single_pixel();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
